// File: rtl/alu_uart_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : alu_uart_ctrl
// Description : Sequences an ALU from a UART link. Three received bytes
//               (operand A, operand B, opcode) are captured onto
//               Data_A/Data_B/Op. The combinational ALU Result is latched one
//               cycle later and handed to the UART transmitter through a
//               tx_start/tx_busy handshake.
// Ports       : clk, rst_n         - clock, asynchronous active-low reset
//               rx_data, rx_done   - received byte and its one-cycle strobe
//               Data_A, Data_B, Op - registered operands/opcode to the ALU
//               Result             - combinational ALU output
//               tx_data, tx_start  - zero-extended result and send strobe
//               tx_busy            - transmitter busy, holds off tx_start
//               busy               - high while executing or sending
//               timeout            - one-cycle inter-byte timeout pulse
// Options     : `define ALU_TIMEOUT_EN builds the inter-byte timeout
//               counter (TIMEOUT_CYCLES). Without it timeout is tied to 0
//               and the controller waits indefinitely for each byte.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_uart_ctrl #(
    parameter int N_BITS         = 6,
    parameter int N_OPS          = 6,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    output logic [N_BITS-1:0] Data_A,
    output logic [N_BITS-1:0] Data_B,
    output logic [N_OPS-1:0]  Op,
    input  logic [N_BITS-1:0] Result,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic              busy,
    output logic              timeout
);

    typedef enum logic [2:0] {
        ST_WAIT_A  = 3'd0,
        ST_WAIT_B  = 3'd1,
        ST_WAIT_OP = 3'd2,
        ST_EXEC    = 3'd3,
        ST_SEND    = 3'd4
    } state_t;

    state_t            state_q;
    logic [N_BITS-1:0] data_a_q;
    logic [N_BITS-1:0] data_b_q;
    logic [N_OPS-1:0]  op_q;
    logic [7:0]        tx_data_q;
    logic              tx_start_q;
    logic              busy_q;

    // Received-byte bits above the operand/opcode width are discarded.
    logic w_rx_unused;
    assign w_rx_unused = ^rx_data;

`ifdef ALU_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic             timeout_q;
    logic             w_expired;

    assign w_expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign timeout   = timeout_q;
`else
    assign timeout   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_WAIT_A;
            data_a_q   <= '0;
            data_b_q   <= '0;
            op_q       <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
`ifdef ALU_TIMEOUT_EN
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            tx_start_q <= 1'b0;
`ifdef ALU_TIMEOUT_EN
            timeout_q  <= 1'b0;
            // Cleared unless a waiting state explicitly counts an idle cycle,
            // which covers both rx_done and every state entry.
            cnt_q      <= '0;
`endif
            case (state_q)
                ST_WAIT_A: begin
                    if (rx_done) begin
                        data_a_q <= rx_data[N_BITS-1:0];
                        state_q  <= ST_WAIT_B;
                    end
                end
                ST_WAIT_B: begin
                    if (rx_done) begin
                        data_b_q <= rx_data[N_BITS-1:0];
                        state_q  <= ST_WAIT_OP;
                    end
`ifdef ALU_TIMEOUT_EN
                    else if (w_expired) begin
                        state_q   <= ST_WAIT_A;
                        timeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                ST_WAIT_OP: begin
                    if (rx_done) begin
                        op_q    <= rx_data[N_OPS-1:0];
                        state_q <= ST_EXEC;
                        busy_q  <= 1'b1;
                    end
`ifdef ALU_TIMEOUT_EN
                    else if (w_expired) begin
                        state_q   <= ST_WAIT_A;
                        timeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                ST_EXEC: begin
                    // Only sample point for Result; later ALU changes are ignored.
                    tx_data_q <= 8'(Result);
                    state_q   <= ST_SEND;
                end
                ST_SEND: begin
                    if (!tx_busy) begin
                        tx_start_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= ST_WAIT_A;
                    end
                end
                default: begin
                    state_q <= ST_WAIT_A;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Data_A   = data_a_q;
    assign Data_B   = data_b_q;
    assign Op       = op_q;
    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;
    assign busy     = busy_q;

endmodule
`default_nettype wire
